// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
// Sequencing and arbitration controller in front of the CPU's 32x32 register
// file. After reset it sweeps every register to zero through the single write
// port. After that it passes core writeback and read port 2 straight through,
// and it lends both ports to a debug requester through a valid/ack handshake.
// A debug request that keeps waiting is force-granted after STARVE_LIMIT cycles.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   core_wAddr/wDin/wEna  core writeback request
//   core_rAddr2           core read port 2 address
//   core_rd2_use          core needs read port 2 this cycle
//   core_stall            core must hold state; its write this cycle is dropped
//   init_done             register sweep complete
//   dbg_req/we/addr/wdata debug request, held stable until dbg_ack
//   dbg_ack               one-cycle completion pulse
//   dbg_rdata             register value sampled at grant (pre-write value)
//   rf_wAddr/wDin/wEna    register file write port
//   rf_rAddr2/rf_rDout2   register file read port 2 (combinational read)
module reg_file_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_wAddr,
  input  logic [DATA_W-1:0] core_wDin,
  input  logic              core_wEna,
  input  logic [ADDR_W-1:0] core_rAddr2,
  input  logic              core_rd2_use,
  output logic              core_stall,
  output logic              init_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wDin,
  output logic              rf_wEna,
  output logic [ADDR_W-1:0] rf_rAddr2,
  input  logic [DATA_W-1:0] rf_rDout2
);

  localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    GRANT = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_initCnt;
  logic [WCNT_W-1:0]   r_waitCnt;
  logic                r_initDone;
  logic [DATA_W-1:0]   r_dbgRdata;
  logic                w_grant;
  logic                w_wEna;
  logic                w_coreWEna;

  // Core writes to r0 are never performed, which keeps r0 reading as zero.
  assign w_coreWEna = core_wEna && (core_wAddr != '0);

  // Grant when the core leaves both ports idle, or when the request has
  // already waited STARVE_LIMIT-1 cycles; only evaluated in RUN.
  assign w_grant = dbg_req && ((!core_wEna && !core_rd2_use) || (r_waitCnt == WAIT_MAX));

  // State register, sweep counter, starvation counter and debug read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_initCnt  <= '0;
      r_waitCnt  <= '0;
      r_initDone <= 1'b0;
      r_dbgRdata <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == INIT) begin
        r_initCnt <= r_initCnt + 1'b1;
        if (r_initCnt == LAST_ADDR) begin
          r_initDone <= 1'b1;
        end
      end
      if (r_state == RUN) begin
        if (!dbg_req || w_grant) begin
          r_waitCnt <= '0;
        end else begin
          r_waitCnt <= r_waitCnt + 1'b1;
        end
      end else if (r_state == GRANT) begin
        r_waitCnt <= '0;
      end
      // Read port 2 still shows the old contents during GRANT, so a debug
      // write returns the value it overwrote.
      if (r_state == GRANT) begin
        r_dbgRdata <= rf_rDout2;
      end
    end
  end

  // Next state and port steering; the core path is the default.
  always_comb begin
    w_nextState = r_state;
    core_stall  = 1'b0;
    dbg_ack     = 1'b0;
    w_wEna      = w_coreWEna;
    rf_wAddr    = core_wAddr;
    rf_wDin     = core_wDin;
    rf_rAddr2   = core_rAddr2;
    case (r_state)
      INIT: begin
        core_stall = 1'b1;
        w_wEna     = 1'b1;
        rf_wAddr   = r_initCnt;
        rf_wDin    = '0;
        if (r_initCnt == LAST_ADDR) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_grant) begin
          w_nextState = GRANT;
        end
      end
      GRANT: begin
        core_stall  = 1'b1;
        w_wEna      = dbg_we && (dbg_addr != '0);
        rf_wAddr    = dbg_addr;
        rf_wDin     = dbg_wdata;
        rf_rAddr2   = dbg_addr;
        w_nextState = ACK;
      end
      ACK: begin
        dbg_ack     = 1'b1;
        w_nextState = RUN;
      end
      default: begin
        w_nextState = INIT;
      end
    endcase
  end

  // The reset state is INIT, which would otherwise assert the write enable
  // while reset is still held.
  assign rf_wEna   = w_wEna && rst_n;
  assign init_done = r_initDone;
  assign dbg_rdata = r_dbgRdata;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
// Directed bench for reg_file_ctrl. It holds a behavioural 32x32 register file
// behind the controller's ports. That file is preloaded with non-zero values so
// that the reset sweep is observable.
module tb_reg_file_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  core_wAddr;
  logic [31:0] core_wDin;
  logic        core_wEna;
  logic [4:0]  core_rAddr2;
  logic        core_rd2_use;
  logic        core_stall;
  logic        init_done;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  rf_wAddr;
  logic [31:0] rf_wDin;
  logic        rf_wEna;
  logic [4:0]  rf_rAddr2;
  logic [31:0] rf_rDout2;

  logic [31:0] rf [32];
  logic        preload;

  int checks   = 0;
  int failures = 0;

  reg_file_ctrl #(
    .DATA_W(32),
    .ADDR_W(5),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_wAddr(core_wAddr),
    .core_wDin(core_wDin),
    .core_wEna(core_wEna),
    .core_rAddr2(core_rAddr2),
    .core_rd2_use(core_rd2_use),
    .core_stall(core_stall),
    .init_done(init_done),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata),
    .rf_wAddr(rf_wAddr),
    .rf_wDin(rf_wDin),
    .rf_wEna(rf_wEna),
    .rf_rAddr2(rf_rAddr2),
    .rf_rDout2(rf_rDout2)
  );

  always #5 clk = ~clk;

  // Behavioural register file: synchronous write, combinational read port 2.
  always @(posedge clk) begin
    if (preload) begin
      for (int j = 0; j < 32; j++) begin
        rf[j] <= 32'hA5A50000 | 32'(j);
      end
    end else if (rf_wEna) begin
      rf[rf_wAddr] <= rf_wDin;
    end
  end

  assign rf_rDout2 = rf[rf_rAddr2];

  // Inputs change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rf_wEna, init_done, dbg_ack, core_stall} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: wEna/done/ack/stall=%b expected 0001",
               {rf_wEna, init_done, dbg_ack, core_stall});
    end
    checks++;
    if (dbg_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_rdata: got %h expected 00000000", dbg_rdata);
    end
  endtask

  // Releases reset and follows the 32-cycle sweep into RUN.
  task automatic test_sweep();
    logic [4:0] a;
    logic       allZero;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      @(negedge clk);
      checks++;
      if ({rf_wEna, rf_wAddr, rf_wDin, core_stall, init_done, dbg_ack} !==
          {1'b1, a, 32'h0, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL sweep_%0d: wEna=%b addr=%0d din=%h stall=%b done=%b ack=%b expected 1 %0d 0 1 0 0",
                 i, rf_wEna, rf_wAddr, rf_wDin, core_stall, init_done, dbg_ack, a);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({init_done, core_stall} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL sweep_done: done/stall=%b expected 10", {init_done, core_stall});
    end
    allZero = 1'b1;
    for (int j = 0; j < 32; j++) begin
      if (rf[j] !== 32'h0) allZero = 1'b0;
    end
    checks++;
    if (allZero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sweep_zero: regfile all-zero=%b expected 1", allZero);
    end
  endtask

  task automatic test_core_write();
    step();
    core_wEna = 1'b1;
    core_wAddr = 5'd5;
    core_wDin = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({rf_wEna, rf_wAddr, rf_wDin, core_stall} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("[TB] FAIL core_wr_r5: wEna=%b addr=%0d din=%h stall=%b expected 1 5 deadbeef 0",
               rf_wEna, rf_wAddr, rf_wDin, core_stall);
    end
    step();
    core_wAddr = 5'd0;
    core_wDin = 32'h1234;
    @(negedge clk);
    checks++;
    if (rf_wEna !== 1'b0) begin
      failures++;
      $display("[TB] FAIL core_wr_r0: wEna=%b expected 0", rf_wEna);
    end
    step();
    core_wAddr = 5'd7;
    core_wDin = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if ({rf_wEna, rf_wAddr} !== {1'b1, 5'd7}) begin
      failures++;
      $display("[TB] FAIL core_wr_r7: wEna=%b addr=%0d expected 1 7", rf_wEna, rf_wAddr);
    end
    step();
    core_wEna = 1'b0;
    checks++;
    if (rf[0] !== 32'h0 || rf[5] !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL core_wr_contents: r0=%h r5=%h expected 00000000 deadbeef", rf[0], rf[5]);
    end
  endtask

  task automatic test_dbg_read();
    dbg_req = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 5'd5;
    @(negedge clk);
    checks++;
    if ({core_stall, dbg_ack} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rd_arb: stall/ack=%b expected 00", {core_stall, dbg_ack});
    end
    step();
    @(negedge clk);
    checks++;
    if ({core_stall, dbg_ack, rf_wEna, rf_rAddr2} !== {3'b100, 5'd5}) begin
      failures++;
      $display("[TB] FAIL rd_grant: stall=%b ack=%b wEna=%b rAddr2=%0d expected 1 0 0 5",
               core_stall, dbg_ack, rf_wEna, rf_rAddr2);
    end
    step();
    @(negedge clk);
    checks++;
    if ({dbg_ack, core_stall, dbg_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      failures++;
      $display("[TB] FAIL rd_ack: ack=%b stall=%b rdata=%h expected 1 0 deadbeef",
               dbg_ack, core_stall, dbg_rdata);
    end
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_ack, dbg_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      failures++;
      $display("[TB] FAIL rd_after: ack=%b rdata=%h expected 0 deadbeef", dbg_ack, dbg_rdata);
    end
  endtask

  task automatic test_starve_write();
    step();
    core_wEna = 1'b1;
    core_wAddr = 5'd9;
    core_wDin = 32'h99;
    core_rd2_use = 1'b1;
    dbg_req = 1'b1;
    dbg_we = 1'b1;
    dbg_addr = 5'd7;
    dbg_wdata = 32'h55;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({core_stall, dbg_ack, rf_wAddr} !== {2'b00, 5'd9}) begin
        failures++;
        $display("[TB] FAIL starve_wait_%0d: stall=%b ack=%b wAddr=%0d expected 0 0 9",
                 k, core_stall, dbg_ack, rf_wAddr);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({core_stall, rf_wEna, rf_wAddr, rf_wDin, rf_rAddr2} !== {2'b11, 5'd7, 32'h55, 5'd7}) begin
      failures++;
      $display("[TB] FAIL starve_grant: stall=%b wEna=%b wAddr=%0d wDin=%h rAddr2=%0d expected 1 1 7 00000055 7",
               core_stall, rf_wEna, rf_wAddr, rf_wDin, rf_rAddr2);
    end
    step();
    @(negedge clk);
    checks++;
    if ({dbg_ack, core_stall, dbg_rdata} !== {2'b10, 32'h0BADF00D}) begin
      failures++;
      $display("[TB] FAIL starve_ack: ack=%b stall=%b rdata=%h expected 1 0 0badf00d",
               dbg_ack, core_stall, dbg_rdata);
    end
    checks++;
    if ({rf_wEna, rf_wAddr, rf[7]} !== {1'b1, 5'd9, 32'h55}) begin
      failures++;
      $display("[TB] FAIL starve_effect: wEna=%b wAddr=%0d r7=%h expected 1 9 00000055",
               rf_wEna, rf_wAddr, rf[7]);
    end
    step();
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    core_wEna = 1'b0;
    core_rd2_use = 1'b0;
  endtask

  // Request held high with an idle core: RUN, GRANT, ACK repeating.
  task automatic test_back_to_back();
    logic expStall;
    logic expAck;
    step();
    dbg_req = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 5'd5;
    for (int i = 0; i < 9; i++) begin
      expStall = ((i % 3) == 1);
      expAck   = ((i % 3) == 2);
      @(negedge clk);
      checks++;
      if ({core_stall, dbg_ack} !== {expStall, expAck}) begin
        failures++;
        $display("[TB] FAIL b2b_%0d: stall/ack=%b expected %b", i, {core_stall, dbg_ack},
                 {expStall, expAck});
      end
      step();
    end
    dbg_req = 1'b0;
    checks++;
    if (dbg_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL b2b_rdata: got %h expected deadbeef", dbg_rdata);
    end
  endtask

  task automatic test_reset_in_grant();
    step();
    dbg_req = 1'b1;
    dbg_we = 1'b1;
    dbg_addr = 5'd7;
    dbg_wdata = 32'h77;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rgrant_stall: got %b expected 1", core_stall);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_wEna, dbg_ack, init_done, dbg_rdata} !== {3'b000, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rgrant_reset: wEna=%b ack=%b done=%b rdata=%h expected 0 0 0 00000000",
               rf_wEna, dbg_ack, init_done, dbg_rdata);
    end
    dbg_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({dbg_ack, rf_wEna} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL rgrant_hold_%0d: ack/wEna=%b expected 00", k, {dbg_ack, rf_wEna});
      end
    end
    // A debug read of r7 stays pending through the sweep and is served after it.
    test_sweep();
    step();
    @(negedge clk);
    checks++;
    if ({core_stall, rf_rAddr2} !== {1'b1, 5'd7}) begin
      failures++;
      $display("[TB] FAIL rgrant_read_grant: stall=%b rAddr2=%0d expected 1 7", core_stall, rf_rAddr2);
    end
    step();
    @(negedge clk);
    checks++;
    if ({dbg_ack, dbg_rdata} !== {1'b1, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rgrant_read_r7: ack=%b rdata=%h expected 1 00000000", dbg_ack, dbg_rdata);
    end
    step();
    dbg_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    preload = 1'b1;
    core_wAddr = '0;
    core_wDin = '0;
    core_wEna = 1'b0;
    core_rAddr2 = '0;
    core_rd2_use = 1'b0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = '0;
    dbg_wdata = '0;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    test_reset();
    test_sweep();
    test_core_write();
    test_dbg_read();
    test_starve_write();
    test_back_to_back();
    test_reset_in_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Sequencing and arbitration controller in front of the 32x32 register file of the multicycle CPU.
- After reset it sweeps all 32 registers to zero through the single write port.
- It then passes core writeback and read port 2 straight through.
- It shares both ports with a debug requester, using a valid/ack handshake and a bounded-starvation policy; the core is held via core_stall while debug owns the ports.

Parameters:
DATA_W, 32, register width.
ADDR_W, 5, register address width (32 entries).
STARVE_LIMIT, 8, max cycles a pending debug request waits before a forced grant (>=1).

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
core_wAddr  in  ADDR_W  core writeback address.
core_wDin  in  DATA_W  core writeback data.
core_wEna  in  1  core writeback enable.
core_rAddr2  in  ADDR_W  core read port 2 address.
core_rd2_use  in  1  core needs read port 2 this cycle.
core_stall  out  1  core must hold state; its write this cycle is not performed.
init_done  out  1  register sweep complete.
dbg_req  in  1  debug request; held with fields stable until dbg_ack.
dbg_we  in  1  1 = write, 0 = read.
dbg_addr  in  ADDR_W  debug register address.
dbg_wdata  in  DATA_W  debug write data.
dbg_ack  out  1  one-cycle completion pulse.
dbg_rdata  out  DATA_W  register value at grant (old value for writes); valid with dbg_ack.
rf_wAddr  out  ADDR_W  to regfile wAddr.
rf_wDin  out  DATA_W  to regfile wDin.
rf_wEna  out  1  to regfile wEna.
rf_rAddr2  out  ADDR_W  to regfile rAddr2.
rf_rDout2  in  DATA_W  from regfile rDout2 (combinational read).

Behaviour:
- State machine has 4 states: INIT, RUN, GRANT, ACK. Counters: init_cnt (ADDR_W bits) and wait_cnt (clog2(STARVE_LIMIT+1) bits).
- Reset (async, any state, including mid-sweep or mid-transaction):
  - state=INIT, init_cnt=0, wait_cnt=0, dbg_rdata=0.
  - init_done=0, dbg_ack=0.
  - While rst_n=0, rf_wEna=0.
- INIT:
  - rf_wEna=1, rf_wAddr=init_cnt, rf_wDin=0; core_stall=1; dbg requests ignored.
  - init_cnt increments each cycle. After the write of address 31 (32 cycles), go to RUN.
  - init_done registers high on entering RUN and stays high until the next reset.
- RUN:
  - Pass-through: rf_wAddr/rf_wDin from core, rf_rAddr2=core_rAddr2, core_stall=0.
  - rf_wEna=core_wEna & (core_wAddr!=0): writes to r0 are suppressed, so r0 reads 0.
  - wait_cnt increments each cycle dbg_req=1 and there is no grant; it clears when dbg_req=0.
  - Go to GRANT at the edge when dbg_req=1 and either (core_wEna=0 and core_rd2_use=0) or wait_cnt==STARVE_LIMIT-1. This bounds debug latency to at most STARVE_LIMIT RUN cycles.
- GRANT (exactly 1 cycle):
  - core_stall=1; the core write is not performed and the core re-presents it later.
  - rf_rAddr2=dbg_addr. If dbg_we, rf_wEna=(dbg_addr!=0) with dbg_addr/dbg_wdata.
  - dbg_rdata captures rf_rDout2 at the edge; this is the pre-write value.
  - wait_cnt clears. Go to ACK.
- ACK (exactly 1 cycle):
  - dbg_ack=1; ports pass through from the core as in RUN; core_stall=0.
  - No grant is possible in this cycle. Go to RUN.
  - The requester drops or changes dbg_req after seeing ack. A dbg_req still high in the following RUN cycle is a new request.
- Back-to-back debug requests: the core gets at least one ACK cycle of progress between grants.
- dbg_rdata holds its value until the next GRANT.

Test Plan:
- Reset, release -> rf_wEna=1 for exactly 32 cycles with addresses 0..31 and data 0; init_done rises on cycle 33; core_stall=1 throughout the sweep.
- RUN, core write r5=0xDEADBEEF -> rf_wEna=1 same cycle; core write r0=0x1234 -> rf_wEna=0.
- Core idle, dbg read r5 -> GRANT next cycle with core_stall=1; dbg_ack the cycle after with dbg_rdata=0xDEADBEEF.
- Core busy every cycle (core_wEna=1), dbg write r7=0x55 with STARVE_LIMIT=8 -> grant occurs after 8 waiting cycles; the core write in GRANT is dropped and core_stall=1; the r7 write occurs; ack has rdata equal to the old r7 value.
- rst_n low during GRANT -> dbg_ack never pulses; the sweep restarts at address 0; a subsequent read of r7 returns 0.
- dbg_req held high continuously -> grants separated by >=1 ACK cycle plus the RUN arbitration cycle; the core sees core_stall=0 in each ACK cycle.
